// File: rtl/dmux_stream_n_way_pkg.sv
// -----------------------------------------------------------------------------
// dmux_stream_n_way_pkg
//   Shared definitions for the 1-to-N stream demultiplexer:
//     - legal range for the channel count N
//     - sel_width(): select width required for a given N, max(1, clog2(N))
//     - state_e: IDLE (nothing owed) / BUSY (held word still owed somewhere)
// -----------------------------------------------------------------------------
package dmux_stream_n_way_pkg;

    localparam int N_MIN = 2;
    localparam int N_MAX = 32;

    // Select width needed to address n channels; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/dmux_onehot_decode.sv
// -----------------------------------------------------------------------------
// dmux_onehot_decode
//   Combinational destination decoder for the stream demultiplexer.
//   Ports:
//     sel      in   SEL_W  destination channel index
//     bcast    in   1      1 = all channels, sel ignored
//     mask     out  N      one-hot of sel, all ones for bcast, zero if invalid
//     invalid  out  1      sel addresses a channel that does not exist (sel >= N)
// -----------------------------------------------------------------------------
module dmux_onehot_decode #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             bcast,
    output logic [N-1:0]     mask,
    output logic             invalid
);

    logic [N-1:0] onehot;

    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = (sel == SEL_W'(i));
        end
    end

    // An out-of-range sel matches no channel, which is exactly the drop case.
    assign mask    = bcast ? '1 : onehot;
    assign invalid = !bcast && (onehot == '0);

endmodule

// File: rtl/dmux_stream_n_way.sv
// -----------------------------------------------------------------------------
// dmux_stream_n_way
//   Registered 1-to-N stream demultiplexer with valid/ready on every port.
//   One held word is shared by all channels; pend marks which channels are
//   still owed it. Unicast runs at full rate, broadcast waits for every channel.
//   Ports:
//     clk        in   1      rising-edge clock
//     rst        in   1      asynchronous, active-high reset
//     in_data    in   WIDTH  input word
//     in_sel     in   SEL_W  destination channel index
//     in_bcast   in   1      send to all channels, in_sel ignored
//     in_valid   in   1      producer offers a word
//     in_ready   out  1      word is accepted this cycle
//     out_data   out  WIDTH  held word, common to all channels
//     out_valid  out  N      channel i holds a pending word
//     out_ready  in   N      consumer i takes the word this cycle
//     err_cnt    out  ERR_W  saturating count of words dropped for in_sel >= N
// -----------------------------------------------------------------------------
module dmux_stream_n_way
    import dmux_stream_n_way_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_bcast,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [N-1:0]     out_valid,
    input  logic [N-1:0]     out_ready,
    output logic [ERR_W-1:0] err_cnt
);

    if (WIDTH < 1 || N < N_MIN || N > N_MAX || SEL_W != sel_width(N)) begin : g_param_check
        $error("dmux_stream_n_way: illegal WIDTH/N/SEL_W combination");
    end

    logic [WIDTH-1:0] hold_data;
    logic [N-1:0]     pend;
    logic [N-1:0]     dec_mask;
    logic             dec_invalid;
    logic             accept;
    state_e           state;

    dmux_onehot_decode #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_decode (
        .sel     (in_sel),
        .bcast   (in_bcast),
        .mask    (dec_mask),
        .invalid (dec_invalid)
    );

    assign state = (pend == '0) ? ST_IDLE : ST_BUSY;

    // Ready when nothing is owed, or every owed channel drains this cycle.
    // Depends only on pend and out_ready, never on in_valid.
    assign in_ready = (state == ST_IDLE) || ((pend & ~out_ready) == '0);
    assign accept   = in_valid && in_ready;

    assign out_valid = pend;
    assign out_data  = hold_data;

    // NOTE: registered state is written only with non-blocking assignments so
    // every flop samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data <= '0;
            pend      <= '0;
            err_cnt   <= '0;
        end else if (accept) begin
            // Accept implies all old pend bits drain now, so the new set
            // simply replaces the old one.
            if (dec_invalid) begin
                pend <= '0;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
            end else begin
                hold_data <= in_data;
                pend      <= dec_mask;
            end
        end else begin
            // Ready on a channel not in pend has no effect.
            pend <= pend & ~out_ready;
        end
    end

endmodule

// File: tb/tb_dmux_stream_n_way.sv
// -----------------------------------------------------------------------------
// tb_dmux_stream_n_way
//   Directed bench for dmux_stream_n_way: a 4-channel instance for reset,
//   unicast, backpressure, broadcast and mixed traffic, plus a 3-channel
//   instance for the out-of-range drop path and err_cnt saturation.
// -----------------------------------------------------------------------------
module tb_dmux_stream_n_way;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 4-channel instance
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_bcast;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] err_cnt;

    // 3-channel instance
    logic [7:0] d3_in_data;
    logic [1:0] d3_in_sel;
    logic       d3_in_bcast;
    logic       d3_in_valid;
    logic       d3_in_ready;
    logic [7:0] d3_out_data;
    logic [2:0] d3_out_valid;
    logic [2:0] d3_out_ready;
    logic [7:0] d3_err_cnt;

    dmux_stream_n_way #(.WIDTH(8), .N(4), .SEL_W(2), .ERR_W(8)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_cnt   (err_cnt)
    );

    dmux_stream_n_way #(.WIDTH(8), .N(3), .SEL_W(2), .ERR_W(8)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (d3_in_data),
        .in_sel    (d3_in_sel),
        .in_bcast  (d3_in_bcast),
        .in_valid  (d3_in_valid),
        .in_ready  (d3_in_ready),
        .out_data  (d3_out_data),
        .out_valid (d3_out_valid),
        .out_ready (d3_out_ready),
        .err_cnt   (d3_err_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Traffic-model state
    logic [3:0] exp_pend;
    logic [7:0] exp_data;
    logic       model_ready;
    logic       accepted;
    logic [3:0] prev_valid;
    logic [3:0] prev_ready;
    int         sent [4];
    int         recv [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        in_data      = '0;
        in_sel       = '0;
        in_bcast     = 1'b0;
        in_valid     = 1'b0;
        out_ready    = '0;
        d3_in_data   = '0;
        d3_in_sel    = '0;
        d3_in_bcast  = 1'b0;
        d3_in_valid  = 1'b0;
        d3_out_ready = '0;

        // Reset state
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_err", 32'(err_cnt), 32'h0);
        check("rst_err3", 32'(d3_err_cnt), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: reset in the middle of a broadcast with pend = 0110
        in_valid = 1'b1; in_bcast = 1'b1; in_data = 8'h77; out_ready = 4'b0000;
        @(negedge clk);
        check("t1_ready_idle", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'b1001;
        @(negedge clk);
        check("t1_pend_all", 32'(out_valid), 32'hF);
        check("t1_ready_busy", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        out_ready = 4'b0000;
        @(negedge clk);
        check("t1_pend_0110", 32'(out_valid), 32'h6);
        rst = 1'b1;
        #1;
        check("t1_rst_valid", 32'(out_valid), 32'h0);
        check("t1_rst_err", 32'(err_cnt), 32'h0);
        check("t1_rst_data", 32'(out_data), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t1_ready_rel", 32'(in_ready), 32'h1);
        check("t1_valid_rel", 32'(out_valid), 32'h0);
        @(posedge clk); #1;

        // 2: unicast stream 0x11->0, 0x22->2, 0x33->3
        out_ready = 4'hF; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h11;
        @(negedge clk);
        check("t2_ready0", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        in_sel = 2'd2; in_data = 8'h22;
        @(negedge clk);
        check("t2_valid1", 32'(out_valid), 32'h1);
        check("t2_data1", 32'(out_data), 32'h11);
        check("t2_ready1", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        in_sel = 2'd3; in_data = 8'h33;
        @(negedge clk);
        check("t2_valid2", 32'(out_valid), 32'h4);
        check("t2_data2", 32'(out_data), 32'h22);
        check("t2_ready2", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t2_valid3", 32'(out_valid), 32'h8);
        check("t2_data3", 32'(out_data), 32'h33);
        @(posedge clk); #1;

        // 3: backpressure on channel 1 for three cycles
        out_ready = 4'b1101; in_valid = 1'b1; in_sel = 2'd1; in_data = 8'hA5;
        @(negedge clk);
        check("t3_ready_first", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        in_sel = 2'd2; in_data = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_valid_held", 32'(out_valid), 32'h2);
            check("t3_ready_low", 32'(in_ready), 32'h0);
            check("t3_data_stable", 32'(out_data), 32'hA5);
            @(posedge clk); #1;
        end
        out_ready = 4'hF;
        @(negedge clk);
        check("t3_ready_release", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t3_valid_next", 32'(out_valid), 32'h4);
        check("t3_data_next", 32'(out_data), 32'h5A);
        @(posedge clk); #1;

        // 4: broadcast 0xC3, drained ch2, then ch0, then ch1+ch3
        out_ready = 4'b0000; in_valid = 1'b1; in_bcast = 1'b1; in_data = 8'hC3;
        @(posedge clk); #1;
        in_bcast = 1'b0; in_sel = 2'd0; in_data = 8'h3C; out_ready = 4'b0100;
        @(negedge clk);
        check("t4_pend_1111", 32'(out_valid), 32'hF);
        check("t4_ready_a", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        out_ready = 4'b0001;
        @(negedge clk);
        check("t4_pend_1011", 32'(out_valid), 32'hB);
        check("t4_ready_b", 32'(in_ready), 32'h0);
        check("t4_data", 32'(out_data), 32'hC3);
        @(posedge clk); #1;
        out_ready = 4'b1010;
        @(negedge clk);
        check("t4_pend_1010", 32'(out_valid), 32'hA);
        check("t4_ready_c", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 4'hF;
        @(negedge clk);
        check("t4_next_valid", 32'(out_valid), 32'h1);
        check("t4_next_data", 32'(out_data), 32'h3C);
        @(posedge clk); #1;

        // 5: drops on the 3-channel instance
        d3_out_ready = 3'b111; d3_in_valid = 1'b1; d3_in_sel = 2'd3; d3_in_data = 8'hEE;
        @(negedge clk);
        check("t5_ready", 32'(d3_in_ready), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_no_valid", 32'(d3_out_valid), 32'h0);
        check("t5_err_one", 32'(d3_err_cnt), 32'h1);
        check("t5_data_kept", 32'(d3_out_data), 32'h0);
        repeat (299) @(posedge clk);
        #1;
        d3_in_valid = 1'b0;
        @(negedge clk);
        check("t5_err_sat", 32'(d3_err_cnt), 32'hFF);
        check("t5_no_valid_sat", 32'(d3_out_valid), 32'h0);
        check("t5_err4_untouched", 32'(err_cnt), 32'h0);
        @(posedge clk); #1;
        d3_in_valid = 1'b1; d3_in_sel = 2'd2; d3_in_data = 8'h9E;
        @(posedge clk); #1;
        d3_in_valid = 1'b0;
        @(negedge clk);
        check("t5_ch2_valid", 32'(d3_out_valid), 32'h4);
        check("t5_ch2_data", 32'(d3_out_data), 32'h9E);
        check("t5_err_hold", 32'(d3_err_cnt), 32'hFF);
        @(posedge clk); #1;

        // 6: random traffic against a pend/data model with delivery counts
        exp_pend   = '0;
        exp_data   = 8'h3C;
        accepted   = 1'b0;
        prev_valid = '0;
        prev_ready = '0;
        in_valid   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sent[i] = 0;
            recv[i] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            // A new offer only after the previous one was taken.
            if (!in_valid || accepted) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_bcast = ($urandom_range(0, 4) == 0);
                in_sel   = 2'($urandom_range(0, 3));
                in_data  = 8'($urandom);
            end
            out_ready = 4'($urandom);
            @(negedge clk);
            model_ready = ((exp_pend & ~out_ready) == 4'b0000);
            check("rnd_valid", 32'(out_valid), 32'(exp_pend));
            check("rnd_ready", 32'(in_ready), 32'(model_ready));
            if (exp_pend != 4'b0000) begin
                check("rnd_data", 32'(out_data), 32'(exp_data));
            end
            for (int i = 0; i < 4; i++) begin
                if (prev_valid[i] && !prev_ready[i]) begin
                    check("rnd_valid_kept", 32'(out_valid[i]), 32'h1);
                end
                if (out_valid[i] && out_ready[i]) begin
                    recv[i]++;
                end
            end
            accepted = in_valid && model_ready;
            if (accepted) begin
                for (int i = 0; i < 4; i++) begin
                    if (in_bcast || (in_sel == 2'(i))) begin
                        sent[i]++;
                    end
                end
                exp_pend = in_bcast ? 4'hF : (4'b0001 << in_sel);
                exp_data = in_data;
            end else begin
                exp_pend = exp_pend & ~out_ready;
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 4'hF;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    recv[i]++;
                end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("rnd_drained", 32'(out_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rnd_count_ch%0d", i), 32'(recv[i]), 32'(sent[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
